// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and widths for the instruction-memory fetch responder.
package imem_fetch_responder_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // WAIT is entered one cycle after accept and leaves when the counter hits zero.
  function automatic logic [CNT_W-1:0] wait_cnt_init(input int lat);
    return CNT_W'(lat - 2);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response channel between the PC updater (master) and imem (slave).
interface imem_fetch_responder_if;
  import imem_fetch_responder_pkg::*;

  logic               req_valid;
  logic [ADDR_W-1:0]  req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [INSTR_W-1:0] resp_data;
  logic [ADDR_W-1:0]  resp_addr;
  logic               resp_err;
  logic               flush;
  logic               pc_stall;

  modport master (
    output req_valid, req_addr, resp_ready, flush,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err, pc_stall
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, flush,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err, pc_stall
  );

endinterface

// File: rtl/imem_fetch_responder_array.sv
// Word storage: synchronous write, read registered on read-enable (read-old on collision).
module imem_array #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the read-out register is reset; memory contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_responder.sv
// Fixed-latency instruction fetch responder with flush, stall and preload port.
// Optional misaligned-address flag on resp_err when IMEM_ALIGN_CHK_EN is defined.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_fetch_responder_if.slave io_fetch,
  input  logic                  i_ld_en,
  input  logic [DEPTH_LOG2-1:0] i_ld_addr,
  input  logic [INSTR_W-1:0]    i_ld_data
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [ADDR_W-1:0]  r_resp_addr;
  logic [ADDR_W-1:0]  w_rd_src;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_rd_en;
  logic [INSTR_W-1:0] w_rd_data;

  assign w_req_ready = ~io_fetch.flush &
                       ((r_state == ST_IDLE) | ((r_state == ST_RESP) & io_fetch.resp_ready));
  assign w_accept    = io_fetch.req_valid & w_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_en     = 1'b0;
    w_rd_src    = r_req_addr;
    if (io_fetch.flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_WAIT: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_RESP;
            w_rd_en     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_RESP: if (io_fetch.resp_ready & ~io_fetch.req_valid) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
      // Single-cycle latency reads straight from the incoming address.
      if (w_accept) begin
        if (LATENCY == 1) begin
          w_state_nxt = ST_RESP;
          w_rd_en     = 1'b1;
          w_rd_src    = io_fetch.req_addr;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = wait_cnt_init(LATENCY);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_addr  <= '0;
      r_resp_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_req_addr  <= io_fetch.req_addr;
      if (w_rd_en)  r_resp_addr <= w_rd_src;
    end
  end

`ifdef IMEM_ALIGN_CHK_EN
  logic r_resp_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_resp_err <= 1'b0;
    else if (w_rd_en) r_resp_err <= w_rd_src[0];
  end
  assign io_fetch.resp_err = r_resp_err;
`else
  assign io_fetch.resp_err = 1'b0;
`endif

  imem_array #(
    .AW (DEPTH_LOG2),
    .DW (INSTR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (i_ld_en),
    .i_waddr (i_ld_addr),
    .i_wdata (i_ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_src[DEPTH_LOG2:1]),
    .o_rdata (w_rd_data)
  );

  assign io_fetch.req_ready  = w_req_ready;
  assign io_fetch.pc_stall   = ~w_req_ready;
  assign io_fetch.resp_valid = (r_state == ST_RESP);
  assign io_fetch.resp_data  = w_rd_data;
  assign io_fetch.resp_addr  = r_resp_addr;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: two instances (LATENCY 2 and 4) checked every cycle
// against a cycles-since-accept model, plus directed literal expectations.
module tb_imem_fetch_responder;

`ifdef IMEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld_en   = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic        rv [2];
  logic        rr [2];
  logic        fl [2];
  logic [15:0] ra [2];
  logic        o_rdy [2], o_stall [2], o_vld [2], o_err [2];
  logic [15:0] o_data [2], o_addr [2];

  imem_fetch_responder_if u_if0 ();
  imem_fetch_responder_if u_if1 ();

  assign u_if0.req_valid  = rv[0];
  assign u_if0.req_addr   = ra[0];
  assign u_if0.resp_ready = rr[0];
  assign u_if0.flush      = fl[0];
  assign u_if1.req_valid  = rv[1];
  assign u_if1.req_addr   = ra[1];
  assign u_if1.resp_ready = rr[1];
  assign u_if1.flush      = fl[1];

  assign o_rdy[0]   = u_if0.req_ready;
  assign o_stall[0] = u_if0.pc_stall;
  assign o_vld[0]   = u_if0.resp_valid;
  assign o_data[0]  = u_if0.resp_data;
  assign o_addr[0]  = u_if0.resp_addr;
  assign o_err[0]   = u_if0.resp_err;
  assign o_rdy[1]   = u_if1.req_ready;
  assign o_stall[1] = u_if1.pc_stall;
  assign o_vld[1]   = u_if1.resp_valid;
  assign o_data[1]  = u_if1.resp_data;
  assign o_addr[1]  = u_if1.resp_addr;
  assign o_err[1]   = u_if1.resp_err;

  imem_fetch_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .io_fetch(u_if0),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  imem_fetch_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst), .io_fetch(u_if1),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a fetch is outstanding from accept until consumed; its word appears
  // LATENCY cycles after accept, read from memory as it was before that edge.
  function automatic int lat(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  logic [15:0] mmem [1024];
  bit          m_busy [2];
  bit          m_vld  [2];
  bit          m_err  [2];
  int          m_age  [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_data [2];
  logic [15:0] m_raddr[2];

  function automatic bit m_ready(input int k);
    return !fl[k] && (!m_busy[k] || (m_vld[k] && rr[k]));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_vld[k] = 0; m_err[k] = 0; m_age[k] = 0;
        m_addr[k] = '0; m_data[k] = '0; m_raddr[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit acc;
        acc = rv[k] && m_ready(k);
        if (fl[k]) begin
          m_busy[k] = 0;
          m_vld[k]  = 0;
        end else begin
          if (m_vld[k] && rr[k]) begin
            m_vld[k]  = 0;
            m_busy[k] = 0;
          end
          if (acc) begin
            m_busy[k] = 1;
            m_age[k]  = 0;
            m_addr[k] = ra[k];
          end else if (m_busy[k] && !m_vld[k]) begin
            m_age[k]++;
          end
          if (m_busy[k] && !m_vld[k] && m_age[k] == lat(k) - 1) begin
            m_vld[k]   = 1;
            m_data[k]  = mmem[m_addr[k][10:1]];
            m_raddr[k] = m_addr[k];
            m_err[k]   = ALIGN && m_addr[k][0];
          end
        end
      end
      if (ld_en) mmem[ld_addr] = ld_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        bit r;
        r = m_ready(k);
        chk($sformatf("u%0d req_ready", k),  16'(o_rdy[k]),   16'(r));
        chk($sformatf("u%0d pc_stall", k),   16'(o_stall[k]), 16'(!r));
        chk($sformatf("u%0d resp_valid", k), 16'(o_vld[k]),   16'(m_vld[k]));
        chk($sformatf("u%0d resp_data", k),  o_data[k],       m_data[k]);
        chk($sformatf("u%0d resp_addr", k),  o_addr[k],       m_raddr[k]);
        chk($sformatf("u%0d resp_err", k),   16'(o_err[k]),   16'(m_err[k]));
      end
    end
  end

  task automatic ld(input int idx, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = 10'(idx); ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rr[k] = 1; fl[k] = 0; ra[k] = '0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst u%0d resp_valid", k), 16'(o_vld[k]), 16'h0);
      chk($sformatf("rst u%0d resp_data", k),  o_data[k],     16'h0);
      chk($sformatf("rst u%0d resp_addr", k),  o_addr[k],     16'h0);
      chk($sformatf("rst u%0d resp_err", k),   16'(o_err[k]), 16'h0);
      chk($sformatf("rst u%0d req_ready", k),  16'(o_rdy[k]), 16'h1);
    end
    #12 rst = 1'b0;

    for (int i = 0; i < 1024; i++) ld(i, 16'(i * 16'h1357 + 16'h2468));
    ld(0, 16'h1234);
    ld(1, 16'hBEEF);
    ld(2, 16'hC0DE);
    ld(5, 16'hA5C3);
    ld(8, 16'h0F10);
    tick();

    // Single fetch, LATENCY 2
    rv[0] = 1; ra[0] = 16'h000A; rr[0] = 1;
    tick();
    rv[0] = 0;
    chk("t1 stall after accept", 16'(o_stall[0]), 16'h1);
    chk("t1 no early valid", 16'(o_vld[0]), 16'h0);
    tick();
    chk("t1 valid", 16'(o_vld[0]), 16'h1);
    chk("t1 data", o_data[0], 16'hA5C3);
    chk("t1 addr", o_addr[0], 16'h000A);
    tick();
    chk("t1 idle", 16'(o_vld[0]), 16'h0);
    tick();

    // Back-to-back 0,2,4
    rv[0] = 1; ra[0] = 16'h0000;
    tick();
    ra[0] = 16'h0002;
    tick();
    chk("b2b r0 data", o_data[0], 16'h1234);
    chk("b2b r0 ready", 16'(o_rdy[0]), 16'h1);
    tick();
    ra[0] = 16'h0004;
    chk("b2b gap", 16'(o_vld[0]), 16'h0);
    tick();
    chk("b2b r1 data", o_data[0], 16'hBEEF);
    chk("b2b r1 addr", o_addr[0], 16'h0002);
    tick();
    rv[0] = 0;
    tick();
    chk("b2b r2 data", o_data[0], 16'hC0DE);
    chk("b2b r2 addr", o_addr[0], 16'h0004);
    tick();
    chk("b2b done", 16'(o_vld[0]), 16'h0);

    // Backpressure
    rv[0] = 1; ra[0] = 16'h000A; rr[0] = 0;
    tick();
    rv[0] = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp valid", 16'(o_vld[0]), 16'h1);
      chk("bp data", o_data[0], 16'hA5C3);
      chk("bp addr", o_addr[0], 16'h000A);
      chk("bp ready low", 16'(o_rdy[0]), 16'h0);
      tick();
    end
    rr[0] = 1;
    #1 chk("bp ready on consume", 16'(o_rdy[0]), 16'h1);
    tick();
    chk("bp complete", 16'(o_vld[0]), 16'h0);

    // Flush in WAIT on the LATENCY-4 instance
    rv[1] = 1; ra[1] = 16'h0006; rr[1] = 1;
    tick();
    rv[1] = 0;
    tick();
    tick();
    fl[1] = 1; rv[1] = 1; ra[1] = 16'h0010;
    #1 chk("fl ready masked", 16'(o_rdy[1]), 16'h0);
    tick();
    fl[1] = 0;
    chk("fl no resp", 16'(o_vld[1]), 16'h0);
    tick();
    rv[1] = 0;
    for (int c = 0; c < 3; c++) begin
      chk("fl wait", 16'(o_vld[1]), 16'h0);
      tick();
    end
    chk("fl new valid", 16'(o_vld[1]), 16'h1);
    chk("fl new data", o_data[1], 16'h0F10);
    chk("fl new addr", o_addr[1], 16'h0010);
    tick();
    chk("fl done", 16'(o_vld[1]), 16'h0);

    // Address alias: 0x0800 wraps to index 0
    rv[0] = 1; ra[0] = 16'h0800;
    tick();
    rv[0] = 0;
    tick();
    chk("alias data", o_data[0], 16'h1234);
    chk("alias addr", o_addr[0], 16'h0800);
    tick();

    // Same-edge preload on the read-out edge returns the old word
    rv[0] = 1; ra[0] = 16'h0004;
    tick();
    rv[0] = 0;
    ld_en = 1; ld_addr = 10'd2; ld_data = 16'h7777;
    tick();
    ld_en = 0;
    chk("collide old", o_data[0], 16'hC0DE);
    tick();
    rv[0] = 1;
    tick();
    rv[0] = 0;
    tick();
    chk("collide new", o_data[0], 16'h7777);
    tick();

    // Async reset mid-WAIT
    rv[0] = 1; ra[0] = 16'h0002; rr[0] = 0;
    tick();
    rv[0] = 0;
    #2 rst = 1;
    #1;
    chk("arst wait state", 16'(o_rdy[0]), 16'h1);
    chk("arst wait valid", 16'(o_vld[0]), 16'h0);
    chk("arst wait data", o_data[0], 16'h0);
    chk("arst wait addr", o_addr[0], 16'h0);
    rst = 0;
    tick();
    tick();
    chk("arst wait no resp", 16'(o_vld[0]), 16'h0);

    // Async reset mid-RESP
    rv[0] = 1;
    tick();
    rv[0] = 0;
    tick();
    chk("arst resp valid before", 16'(o_vld[0]), 16'h1);
    chk("arst resp data before", o_data[0], 16'hBEEF);
    #2 rst = 1;
    #1;
    chk("arst resp valid", 16'(o_vld[0]), 16'h0);
    chk("arst resp data", o_data[0], 16'h0);
    chk("arst resp addr", o_addr[0], 16'h0);
    chk("arst resp ready", 16'(o_rdy[0]), 16'h1);
    rst = 0;
    rr[0] = 1;
    tick();
    chk("arst resp gone", 16'(o_vld[0]), 16'h0);

    // Misaligned address
    rv[0] = 1; ra[0] = 16'h0003;
    tick();
    rv[0] = 0;
    tick();
    chk("align data", o_data[0], 16'hBEEF);
    chk("align addr", o_addr[0], 16'h0003);
    chk("align err", 16'(o_err[0]), 16'(ALIGN));
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
